// File: rtl/pwm_capture_16bits_if.sv
// Bundle of the PWM capture control, line input and measurement outputs.
// master: the side that drives enable/pwm_in and consumes measurements.
// slave:  the capture block itself.
interface pwm_capture_16bits_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   pwm_in;
  logic [COUNT_WIDTH-1:0] high_count;
  logic [COUNT_WIDTH-1:0] period_count;
  logic                   meas_valid;
  logic                   timeout;
  logic                   level;
  logic [1:0]             dbg_state;

  modport master (
    output enable,
    output pwm_in,
    input  high_count,
    input  period_count,
    input  meas_valid,
    input  timeout,
    input  level,
    input  dbg_state
  );

  modport slave (
    input  enable,
    input  pwm_in,
    output high_count,
    output period_count,
    output meas_valid,
    output timeout,
    output level,
    output dbg_state
  );
endinterface

// File: rtl/pwm_capture_16bits.sv
// pwm_capture_16bits
// Measures the high time and the rising-to-rising period of a PWM line in
// clk cycles and publishes each completed measurement with a one-cycle
// meas_valid strobe.
//
// Optional feature: define PWMCAP_GLITCH_FILTER_EN to insert a stability
// filter after the synchronizer; the filtered level only changes after
// FILTER_LEN consecutive identical synchronized samples.
//
// Handshake: meas_valid is a one-cycle strobe with no back-pressure; in the
// cycle it is high, high_count/period_count carry the new measurement and
// they hold that value until the next strobe (or reset).
//
// dbg_state exposes the FSM state: 0 IDLE, 1 WAIT_RISE, 2 HIGH, 3 LOW.
module pwm_capture_16bits #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                clk,
  input  logic                reset,
  pwm_capture_16bits_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } state_t;

  // Reject parameter values the input path cannot support.
  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("pwm_capture_16bits: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  // ---------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_lvl;
  logic                   r_s_d;
  logic                   w_rise;
  logic                   w_fall;

  // Multi-flop synchronizer for the asynchronous pwm_in pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PWMCAP_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           r_filt;
  logic [FCW-1:0] r_fcnt;

  // Stability filter: count consecutive samples that disagree with the
  // current filtered level; adopt the new level on the FILTER_LEN-th one.
  // Any agreeing sample restarts the count, so short pulses never pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (w_s == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
      r_filt <= w_s;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FCW'(1);
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = w_s;
`endif

  // Delayed copy of the (filtered) level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_lvl;
    end
  end

  assign w_rise = w_lvl & ~r_s_d;
  assign w_fall = ~w_lvl & r_s_d;

  // ---------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] w_cnt_nxt;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic                   w_cnt_sat;
  logic [COUNT_WIDTH-1:0] r_hi_tmp;
  logic [COUNT_WIDTH-1:0] w_hi_tmp_nxt;
  logic [COUNT_WIDTH-1:0] r_high_count;
  logic [COUNT_WIDTH-1:0] w_high_nxt;
  logic [COUNT_WIDTH-1:0] r_period_count;
  logic [COUNT_WIDTH-1:0] w_period_nxt;
  logic                   r_meas_valid;
  logic                   w_valid_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;

  assign w_cnt_inc = r_cnt + COUNT_WIDTH'(1);
  assign w_cnt_sat = &r_cnt;

  // State and measurement registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_hi_tmp       <= '0;
      r_high_count   <= '0;
      r_period_count <= '0;
      r_meas_valid   <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_hi_tmp       <= w_hi_tmp_nxt;
      r_high_count   <= w_high_nxt;
      r_period_count <= w_period_nxt;
      r_meas_valid   <= w_valid_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  // Next-state and datapath decode.
  // cnt is 0 in the cycle after a rise, so the cycle count since the rise is
  // always cnt+1; both the high time and the period are taken as cnt+1.
  // Saturation wins over an edge in the same cycle so cnt can never wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_tmp_nxt  = r_hi_tmp;
    w_high_nxt    = r_high_count;
    w_period_nxt  = r_period_count;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;

    if (!bus.enable) begin
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = '0;
      w_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_cnt_sat) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_RISE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_fall) begin
              w_hi_tmp_nxt = w_cnt_inc;
              w_state_nxt  = ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (w_cnt_sat) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_RISE;
          end else if (w_rise) begin
            w_high_nxt    = r_hi_tmp;
            w_period_nxt  = w_cnt_inc;
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_HIGH;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.high_count   = r_high_count;
  assign bus.period_count = r_period_count;
  assign bus.meas_valid   = r_meas_valid;
  assign bus.timeout      = r_timeout;
  assign bus.level        = w_lvl;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Directed bench for pwm_capture_16bits: a 16-bit instance for the main
// scenarios and an 8-bit instance for saturation, both on one pwm line.
module tb_pwm_capture_16bits;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_LOW       = 2'd3;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic pwm  = 1'b0;
  logic en16 = 1'b0;
  logic en8  = 1'b0;

  pwm_capture_16bits_if #(.COUNT_WIDTH(16)) bus16 ();
  pwm_capture_16bits_if #(.COUNT_WIDTH(8))  bus8 ();

  assign bus16.pwm_in = pwm;
  assign bus16.enable = en16;
  assign bus8.pwm_in  = pwm;
  assign bus8.enable  = en8;

  pwm_capture_16bits #(.COUNT_WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(4)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  pwm_capture_16bits #(.COUNT_WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Scoreboard: expected {high_count, period_count} per instance
  logic [31:0] exp16_q[$];
  logic [31:0] exp8_q[$];

  always @(negedge clk) begin
    if (reset && bus16.meas_valid === 1'b1) begin
      check("dut16_valid_expected", 32'(exp16_q.size() > 0), 32'd1);
      if (exp16_q.size() > 0)
        check("dut16_meas", {bus16.high_count, bus16.period_count}, exp16_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && bus8.meas_valid === 1'b1) begin
      check("dut8_valid_expected", 32'(exp8_q.size() > 0), 32'd1);
      if (exp8_q.size() > 0)
        check("dut8_meas", {16'(bus8.high_count), 16'(bus8.period_count)}, exp8_q.pop_front());
    end
  end

  // Driver tasks
  int          tgt   = 16;
  logic        armed = 1'b0;
  logic [31:0] prev  = '0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A rise completes the previous period, so its measurement is expected now.
  task automatic start_rise();
    if (armed) begin
      if (tgt == 16) exp16_q.push_back(prev);
      else           exp8_q.push_back(prev);
    end
    pwm = 1'b1;
  endtask

  task automatic run_period(input int hi, input int per);
    start_rise();
    tick(hi);
    pwm = 1'b0;
    tick(per - hi);
    prev  = {16'(hi), 16'(per)};
    armed = 1'b1;
  endtask

`ifdef PWMCAP_GLITCH_FILTER_EN
  // 10/25 period with a 2-cycle low glitch in the high phase and a 2-cycle
  // high glitch in the low phase.
  task automatic glitch_period();
    start_rise();
    tick(4); pwm = 1'b0; tick(2); pwm = 1'b1; tick(4);
    pwm = 1'b0; tick(6); pwm = 1'b1; tick(2); pwm = 1'b0; tick(7);
    prev  = {16'd10, 16'd25};
    armed = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset with the line toggling ----
    tick(1);
    for (int i = 0; i < 6; i++) begin
      pwm = ~pwm;
      tick(2);
    end
    check("rst_high_count",   32'(bus16.high_count),   32'd0);
    check("rst_period_count", 32'(bus16.period_count), 32'd0);
    check("rst_meas_valid",   32'(bus16.meas_valid),   32'd0);
    check("rst_timeout",      32'(bus16.timeout),      32'd0);
    check("rst_level",        32'(bus16.level),        32'd0);
    check("rst_state",        32'(bus16.dbg_state),    32'(ST_IDLE));
    check("rst8_level",       32'(bus8.level),         32'd0);
    pwm = 1'b0;
    tick(1);
    reset = 1'b1;

    // ---- Enabled off: line toggles, nothing measured ----
    for (int i = 0; i < 10; i++) begin
      pwm = ~pwm;
      tick(2);
    end
    pwm = 1'b0;
    tick(12);
    check("dis_high_count",   32'(bus16.high_count),   32'd0);
    check("dis_period_count", 32'(bus16.period_count), 32'd0);
    check("dis_level",        32'(bus16.level),        32'd0);
    check("dis_state",        32'(bus16.dbg_state),    32'(ST_IDLE));

    // ---- Steady 10/25 ----
    tgt = 16; armed = 1'b0;
    en16 = 1'b1;
    tick(3);
    check("en_state_wait_rise", 32'(bus16.dbg_state), 32'(ST_WAIT_RISE));
    run_period(10, 25);
    check("first_rise_no_meas", 32'(bus16.high_count), 32'd0);
    for (int i = 0; i < 3; i++) run_period(10, 25);
    check("steady_drained",      32'(exp16_q.size()),       32'd0);
    check("steady_high_count",   32'(bus16.high_count),     32'd10);
    check("steady_period_count", 32'(bus16.period_count),   32'd25);

    // ---- Duty step 10/25 -> 20/25 ----
    for (int i = 0; i < 3; i++) run_period(20, 25);
    check("step_drained",    32'(exp16_q.size()),   32'd0);
    check("step_high_count", 32'(bus16.high_count), 32'd20);

    // ---- Disable during LOW ----
    run_period(10, 25);
    start_rise();
    tick(10);
    pwm = 1'b0;
    tick(5);
    en16 = 1'b0;
    tick(2);
    check("middis_state",  32'(bus16.dbg_state),    32'(ST_IDLE));
    check("middis_high",   32'(bus16.high_count),   32'd10);
    check("middis_period", 32'(bus16.period_count), 32'd25);
    check("middis_tmo",    32'(bus16.timeout),      32'd0);
    tick(3);
    en16 = 1'b1;
    armed = 1'b0;
    tick(10);
    run_period(7, 20);
    run_period(7, 20);
    check("reen_drained", 32'(exp16_q.size()),     32'd0);
    check("reen_high",    32'(bus16.high_count),   32'd7);
    check("reen_period",  32'(bus16.period_count), 32'd20);

    // ---- Asynchronous reset during HIGH ----
    start_rise();
    tick(5);
    #3;
    reset = 1'b0;
    #1;
    check("areset_high",   32'(bus16.high_count),   32'd0);
    check("areset_period", 32'(bus16.period_count), 32'd0);
    check("areset_state",  32'(bus16.dbg_state),    32'(ST_IDLE));
    check("areset_level",  32'(bus16.level),        32'd0);
    pwm = 1'b0;
    tick(3);
    reset = 1'b1;
    armed = 1'b0;
    tick(3);
    run_period(10, 25);
    check("areset_first_rise_no_meas", 32'(bus16.period_count), 32'd0);
    run_period(10, 25);
    check("areset_drained", 32'(exp16_q.size()),     32'd0);
    check("areset_remeas",  32'(bus16.period_count), 32'd25);

    // ---- Saturation on the 8-bit instance ----
    en16 = 1'b0;
    tick(2);
    tgt = 8; armed = 1'b0;
    en8 = 1'b1;
    tick(3);
    run_period(10, 25);
    run_period(10, 25);
    start_rise();
    armed = 1'b0;
    tick(250);
    check("sat_not_yet", 32'(bus8.timeout), 32'd0);
    tick(50);
    check("sat_timeout", 32'(bus8.timeout),      32'd1);
    check("sat_level",   32'(bus8.level),        32'd1);
    check("sat_high",    32'(bus8.high_count),   32'd10);
    check("sat_period",  32'(bus8.period_count), 32'd25);
    check("sat_state",   32'(bus8.dbg_state),    32'(ST_WAIT_RISE));
    check("sat_drained", 32'(exp8_q.size()),     32'd0);
    pwm = 1'b0;
    tick(7);
    run_period(5, 12);
    check("sat_first_rise_tmo_held", 32'(bus8.timeout), 32'd1);
    run_period(5, 12);
    check("resume_tmo_cleared", 32'(bus8.timeout),      32'd0);
    check("resume_high",        32'(bus8.high_count),   32'd5);
    check("resume_period",      32'(bus8.period_count), 32'd12);
    check("resume_drained",     32'(exp8_q.size()),     32'd0);
    en8 = 1'b0;

`ifdef PWMCAP_GLITCH_FILTER_EN
    // ---- Glitch filter ----
    tgt = 16; armed = 1'b0;
    en16 = 1'b1;
    tick(5);
    for (int i = 0; i < 3; i++) glitch_period();
    check("glitch_drained", 32'(exp16_q.size()),     32'd0);
    check("glitch_high",    32'(bus16.high_count),   32'd10);
    check("glitch_period",  32'(bus16.period_count), 32'd25);
    pwm = 1'b1;
    tick(3);
    pwm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("short_pulse_level", 32'(bus16.level), 32'd0);
      tick(1);
    end
    check("short_pulse_state", 32'(bus16.dbg_state), 32'(ST_LOW));
`endif

    tick(5);
    check("final_q16_empty", 32'(exp16_q.size()), 32'd0);
    check("final_q8_empty",  32'(exp8_q.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
